r_clk_module: RTL and testbench

Read-side control block of the asynchronous FIFO, running entirely in the read clock domain. It owns the binary and Gray read pointers, the read address into the dual-port memory and the registered empty flag. It also provides a fill level, an almost-empty flag and a read-data-valid strobe for a synchronous-read memory. It pairs with w_clk_module: it consumes that module's Gray write pointer and returns its own Gray read pointer.

---
 rtl/binary_to_gray.sv | 11 +
 rtl/d_ff_async.sv | 18 +
 rtl/gray_to_binary.sv | 17 +
 rtl/two_ff_synchronizer.sv | 24 ++
 rtl/r_clk_module.sv | 83 ++++++++
 tb/tb_r_clk_module.sv | 210 +++++++++++++++++++++
 6 files changed

// File: rtl/binary_to_gray.sv
// rtl/binary_to_gray.sv - combinational binary to reflected Gray conversion
module binary_to_gray #(
   parameter int N = 4
) (
   input  logic [N-1:0] bin,
   output logic [N-1:0] gray
);

   assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/d_ff_async.sv
// rtl/d_ff_async.sv - generic register with asynchronous active-low reset
module d_ff_async #(
   parameter int               WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Capture d every edge; drop to RESET_VALUE the instant reset asserts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= RESET_VALUE;
      else        q <= d;
   end

endmodule

// File: rtl/gray_to_binary.sv
// rtl/gray_to_binary.sv - combinational reflected Gray to binary conversion
module gray_to_binary #(
   parameter int N = 4
) (
   input  logic [N-1:0] gray,
   output logic [N-1:0] bin
);

   // Each binary bit is the XOR of all Gray bits at or above its position
   genvar i;
   generate
      for (i = 0; i < N; i++) begin : g_bit
         assign bin[i] = ^(gray >> i);
      end
   endgenerate

endmodule

// File: rtl/two_ff_synchronizer.sv
// rtl/two_ff_synchronizer.sv - two-flop synchronizer for a Gray-coded bus
module two_ff_synchronizer #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // First stage may go metastable; second stage gives it a full cycle to settle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/r_clk_module.sv
// rtl/r_clk_module.sv - async FIFO read-side pointer, empty and fill-level control
module r_clk_module #(
   parameter int ADDRESS_SIZE        = 4,
   parameter int ALMOST_EMPTY_THRESH = 1
) (
   input  logic                    r_clk,
   input  logic                    rrst_n,
   input  logic                    r_en,
   input  logic [ADDRESS_SIZE:0]   w_ptr,
   output logic [ADDRESS_SIZE:0]   r_ptr,
   output logic [ADDRESS_SIZE-1:0] r_addr,
   output logic                    r_empty,
   output logic                    r_almost_empty,
   output logic [ADDRESS_SIZE:0]   r_count,
   output logic                    r_valid
);

   localparam int PTR_W = ADDRESS_SIZE + 1;

   logic [PTR_W-1:0] r_bin;
   logic [PTR_W-1:0] r_bnext;
   logic [PTR_W-1:0] r_gnext;
   logic [PTR_W-1:0] rq2_wptr;
   logic [PTR_W-1:0] rq2_wbin;
   logic [PTR_W-1:0] fill_next;
   logic             accept;
   logic             empty_next;
   logic             almost_next;

   // A pop is only honoured while the registered flag says data is present
   assign accept  = r_en & ~r_empty;
   assign r_bnext = r_bin + PTR_W'(accept);
   assign r_addr  = r_bin[ADDRESS_SIZE-1:0];

   binary_to_gray #(.N(PTR_W)) u_bin2gray (
      .bin  (r_bnext),
      .gray (r_gnext)
   );

   two_ff_synchronizer #(.WIDTH(PTR_W)) u_wptr_sync (
      .clk   (r_clk),
      .rst_n (rrst_n),
      .d     (w_ptr),
      .q     (rq2_wptr)
   );

   gray_to_binary #(.N(PTR_W)) u_gray2bin (
      .gray (rq2_wptr),
      .bin  (rq2_wbin)
   );

   // Flags are computed from the post-pop pointer so the draining pop clears data at once
   assign empty_next  = (r_gnext == rq2_wptr);
   assign fill_next   = rq2_wbin - r_bnext;
   assign almost_next = (fill_next <= PTR_W'(ALMOST_EMPTY_THRESH));

   d_ff_async #(.WIDTH(PTR_W), .RESET_VALUE('0)) u_rbin_reg (
      .clk (r_clk), .rst_n (rrst_n), .d (r_bnext), .q (r_bin)
   );

   // Gray pointer is registered straight from r_bnext so the write domain never sees a decode glitch
   d_ff_async #(.WIDTH(PTR_W), .RESET_VALUE('0)) u_rptr_reg (
      .clk (r_clk), .rst_n (rrst_n), .d (r_gnext), .q (r_ptr)
   );

   d_ff_async #(.WIDTH(1), .RESET_VALUE(1'b1)) u_empty_reg (
      .clk (r_clk), .rst_n (rrst_n), .d (empty_next), .q (r_empty)
   );

   d_ff_async #(.WIDTH(1), .RESET_VALUE(1'b1)) u_almost_reg (
      .clk (r_clk), .rst_n (rrst_n), .d (almost_next), .q (r_almost_empty)
   );

   d_ff_async #(.WIDTH(PTR_W), .RESET_VALUE('0)) u_count_reg (
      .clk (r_clk), .rst_n (rrst_n), .d (fill_next), .q (r_count)
   );

   // Memory samples r_addr on the accept edge, so read data lands one cycle later
   d_ff_async #(.WIDTH(1), .RESET_VALUE(1'b0)) u_valid_reg (
      .clk (r_clk), .rst_n (rrst_n), .d (accept), .q (r_valid)
   );

endmodule

// File: tb/tb_r_clk_module.sv
// tb/tb_r_clk_module.sv - directed self-checking bench for r_clk_module
module tb_r_clk_module;

   logic       r_clk = 1'b0;
   logic       rrst_n = 1'b1;
   logic       r_en = 1'b0;
   logic [3:0] w_ptr = 4'd0;
   logic [3:0] r_ptr;
   logic [2:0] r_addr;
   logic       r_empty;
   logic       r_almost_empty;
   logic [3:0] r_count;
   logic       r_valid;

   int errors = 0;
   int checks = 0;

   r_clk_module #(.ADDRESS_SIZE(3), .ALMOST_EMPTY_THRESH(1)) dut (
      .r_clk          (r_clk),
      .rrst_n         (rrst_n),
      .r_en           (r_en),
      .w_ptr          (w_ptr),
      .r_ptr          (r_ptr),
      .r_addr         (r_addr),
      .r_empty        (r_empty),
      .r_almost_empty (r_almost_empty),
      .r_count        (r_count),
      .r_valid        (r_valid)
   );

   always #5 r_clk = ~r_clk;

   task automatic step();
      @(posedge r_clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rrst_n = 1'b0;
      #1;
      checks++;
      if ({r_ptr, r_addr, r_empty, r_almost_empty, r_count, r_valid} !== {4'd0, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset ptr=%h addr=%0d empty=%b ae=%b count=%0d valid=%b exp ptr=0 addr=0 empty=1 ae=1 count=0 valid=0",
                  r_ptr, r_addr, r_empty, r_almost_empty, r_count, r_valid);
      end
      @(negedge r_clk);
      rrst_n = 1'b1;
   endtask

   task automatic test_pop_empty();
      r_en = 1'b1;
      w_ptr = 4'd0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if ({r_addr, r_ptr, r_valid, r_empty} !== {3'd0, 4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL pop_empty cyc%0d addr=%0d ptr=%h valid=%b empty=%b exp addr=0 ptr=0 valid=0 empty=1",
                     i, r_addr, r_ptr, r_valid, r_empty);
         end
      end
      r_en = 1'b0;
   endtask

   task automatic test_latency();
      w_ptr = 4'b0010;
      step();
      step();
      checks++;
      if ({r_empty, r_count} !== {1'b1, 4'd0}) begin
         errors++;
         $display("FAIL latency_edge2 empty=%b count=%0d exp empty=1 count=0", r_empty, r_count);
      end
      step();
      checks++;
      if ({r_empty, r_count, r_almost_empty} !== {1'b0, 4'd3, 1'b0}) begin
         errors++;
         $display("FAIL latency_edge3 empty=%b count=%0d ae=%b exp empty=0 count=3 ae=0", r_empty, r_count, r_almost_empty);
      end
   endtask

   task automatic test_drain();
      logic [2:0] exp_addr [4] = '{3'd1, 3'd2, 3'd3, 3'd3};
      logic [3:0] exp_cnt  [4] = '{4'd2, 4'd1, 4'd0, 4'd0};
      logic [3:0] exp_ptr  [4] = '{4'b0001, 4'b0011, 4'b0010, 4'b0010};
      logic       exp_val  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic       exp_ae   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      logic       exp_emp  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      checks++;
      if (r_addr !== 3'd0) begin
         errors++;
         $display("FAIL drain_start addr=%0d exp 0", r_addr);
      end
      r_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if ({r_addr, r_count, r_ptr, r_valid, r_almost_empty, r_empty} !==
             {exp_addr[i], exp_cnt[i], exp_ptr[i], exp_val[i], exp_ae[i], exp_emp[i]}) begin
            errors++;
            $display("FAIL drain edge%0d addr=%0d count=%0d ptr=%h valid=%b ae=%b empty=%b exp addr=%0d count=%0d ptr=%h valid=%b ae=%b empty=%b",
                     i + 1, r_addr, r_count, r_ptr, r_valid, r_almost_empty, r_empty,
                     exp_addr[i], exp_cnt[i], exp_ptr[i], exp_val[i], exp_ae[i], exp_emp[i]);
         end
      end
      r_en = 1'b0;
   endtask

   task automatic test_wrap();
      logic [2:0] a1 [5] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
      logic [3:0] p1 [5] = '{4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
      logic [3:0] c1 [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
      logic [2:0] a2 [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
      logic [3:0] p2 [6] = '{4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001};
      logic [3:0] c2 [6] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
      r_en = 1'b1;
      w_ptr = 4'b1100;
      for (int i = 0; i < 3; i++) step();
      checks++;
      if ({r_empty, r_count, r_addr} !== {1'b0, 4'd5, 3'd3}) begin
         errors++;
         $display("FAIL wrap_visible empty=%b count=%0d addr=%0d exp empty=0 count=5 addr=3", r_empty, r_count, r_addr);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if ({r_addr, r_ptr, r_count, r_empty} !== {a1[i], p1[i], c1[i], (i == 4)}) begin
            errors++;
            $display("FAIL wrap_a pop%0d addr=%0d ptr=%h count=%0d empty=%b exp addr=%0d ptr=%h count=%0d empty=%b",
                     i, r_addr, r_ptr, r_count, r_empty, a1[i], p1[i], c1[i], (i == 4));
         end
      end
      w_ptr = 4'b1001;
      for (int i = 0; i < 3; i++) step();
      checks++;
      if ({r_empty, r_count, r_addr} !== {1'b0, 4'd6, 3'd0}) begin
         errors++;
         $display("FAIL wrap_visible2 empty=%b count=%0d addr=%0d exp empty=0 count=6 addr=0", r_empty, r_count, r_addr);
      end
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if ({r_addr, r_ptr, r_count, r_almost_empty, r_empty} !== {a2[i], p2[i], c2[i], (i >= 4), (i == 5)}) begin
            errors++;
            $display("FAIL wrap_b pop%0d addr=%0d ptr=%h count=%0d ae=%b empty=%b exp addr=%0d ptr=%h count=%0d ae=%b empty=%b",
                     i, r_addr, r_ptr, r_count, r_almost_empty, r_empty, a2[i], p2[i], c2[i], (i >= 4), (i == 5));
         end
      end
      step();
      checks++;
      if ({r_valid, r_ptr, r_empty} !== {1'b0, 4'b1001, 1'b1}) begin
         errors++;
         $display("FAIL wrap_hold valid=%b ptr=%h empty=%b exp valid=0 ptr=9 empty=1", r_valid, r_ptr, r_empty);
      end
      r_en = 1'b0;
   endtask

   task automatic test_mid_reset();
      w_ptr = 4'b0010;
      for (int i = 0; i < 3; i++) step();
      checks++;
      if ({r_count, r_empty} !== {4'd5, 1'b0}) begin
         errors++;
         $display("FAIL midrst_pre count=%0d empty=%b exp count=5 empty=0", r_count, r_empty);
      end
      r_en = 1'b1;
      #2 rrst_n = 1'b0;
      #1;
      checks++;
      if ({r_ptr, r_addr, r_empty, r_almost_empty, r_count, r_valid} !== {4'd0, 3'd0, 1'b1, 1'b1, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL midrst_async ptr=%h addr=%0d empty=%b ae=%b count=%0d valid=%b exp ptr=0 addr=0 empty=1 ae=1 count=0 valid=0",
                  r_ptr, r_addr, r_empty, r_almost_empty, r_count, r_valid);
      end
      #1 rrst_n = 1'b1;
      step();
      step();
      checks++;
      if ({r_count, r_empty, r_valid} !== {4'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL midrst_edge2 count=%0d empty=%b valid=%b exp count=0 empty=1 valid=0", r_count, r_empty, r_valid);
      end
      step();
      checks++;
      if ({r_count, r_empty, r_almost_empty} !== {4'd3, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL midrst_edge3 count=%0d empty=%b ae=%b exp count=3 empty=0 ae=0", r_count, r_empty, r_almost_empty);
      end
      step();
      checks++;
      if ({r_count, r_valid, r_addr} !== {4'd2, 1'b1, 3'd1}) begin
         errors++;
         $display("FAIL midrst_edge4 count=%0d valid=%b addr=%0d exp count=2 valid=1 addr=1", r_count, r_valid, r_addr);
      end
      r_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_pop_empty();
      test_latency();
      test_drain();
      test_wrap();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
